ram_arbiter: RTL and testbench

Shares the 16-byte program/data RAM between the CPU datapath (MAR address, bus data, `ramoa`/`ramwa` strobes) and an external host loader port. The block stalls the CPU only at an instruction boundary, grants the host a bounded burst, and then forces at least one CPU instruction before the host can take the RAM again. It sits between the CPU-side RAM strobes and the `ram` instance on the board.

---
 rtl/ram_arbiter_pkg.sv | 13 +
 rtl/ram_arbiter_burst_counter.sv | 31 +++
 rtl/ram_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding and default burst limit.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOST  = 2'd2,
    ST_COOL  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_MAXBURST = 16;

endpackage

// File: rtl/ram_arbiter_burst_counter.sv
// Counts host accepts within one grant; at_limit flags the accept that reaches MAXBURST.
module burst_counter
  import ram_arbiter_pkg::*;
#(
  parameter int MAXBURST = DEFAULT_MAXBURST,
  localparam int CW = $clog2(MAXBURST + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          at_limit
);

  localparam logic [CW-1:0] LAST = CW'(MAXBURST - 1);

  // Exact-equality compare: the FSM leaves HOST on this accept, so the count never wraps.
  assign at_limit = inc && (count == LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the shared program/data RAM between the CPU datapath and a host loader,
// stalling the CPU only at instruction boundaries and bounding each host burst.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int MAXBURST = DEFAULT_MAXBURST
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cpu_ramoa,
  input  logic          cpu_ramwa,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          cpu_boundary,
  output logic          cpu_hold,
  input  logic          host_req,
  output logic          host_gnt,
  input  logic          host_valid,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_oe,
  input  logic [DW-1:0] ram_rdata,
  output logic          err,
  output arb_state_t    dbg_state
);

  localparam int CW = $clog2(MAXBURST + 1);

  arb_state_t    state;
  logic          in_host;
  logic          accept;
  logic          at_limit;
  logic [CW-1:0] burst_count;

  assign in_host   = (state == ST_HOST);
  assign accept    = in_host && host_valid && host_ready;
  assign dbg_state = state;

  // Counter is held clear outside HOST so every grant starts from zero.
  burst_counter #(.MAXBURST(MAXBURST)) u_burst (
    .clk      (clk),
    .clr      (clr),
    .clear    (!in_host),
    .inc      (accept),
    .count    (burst_count),
    .at_limit (at_limit)
  );

  // Handshake: a host transfer is accepted on any edge where host_valid && host_ready;
  // host_ready is high for the whole HOST state, so accepts may issue every cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= ST_CPU;
      cpu_hold    <= 1'b0;
      host_gnt    <= 1'b0;
      host_ready  <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      err         <= 1'b0;
    end else begin
      host_rvalid <= accept && !host_we;
      if (accept && !host_we) host_rdata <= ram_rdata;
      if (in_host && (cpu_ramoa || cpu_ramwa)) err <= 1'b1;

      unique case (state)
        ST_CPU: begin
          if (host_req) begin
            state    <= ST_DRAIN;
            cpu_hold <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!host_req) begin
            state    <= ST_CPU;
            cpu_hold <= 1'b0;
          end else if (cpu_boundary) begin
            state      <= ST_HOST;
            host_gnt   <= 1'b1;
            host_ready <= 1'b1;
          end
        end
        ST_HOST: begin
          if (!host_req || at_limit) begin
            state      <= host_req ? ST_COOL : ST_CPU;
            cpu_hold   <= 1'b0;
            host_gnt   <= 1'b0;
            host_ready <= 1'b0;
          end
        end
        ST_COOL: begin
          // Boundary low means the CPU has moved past step 0 and made progress.
          if (!cpu_boundary) state <= ST_CPU;
        end
        default: state <= ST_CPU;
      endcase
    end
  end

  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = clr && cpu_ramwa;
    ram_oe    = cpu_ramoa;
    cpu_rdata = ram_rdata;
    if (in_host) begin
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
      ram_we    = clr && host_valid && host_we;
      ram_oe    = host_valid && !host_we;
      cpu_rdata = '0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16x8 RAM and MAXBURST=4.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic       cpu_ramoa, cpu_ramwa, cpu_boundary;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cpu_hold;
  logic       host_req, host_gnt, host_valid, host_we, host_ready, host_rvalid;
  logic [3:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic       ram_we, ram_oe, err;
  arb_state_t dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [16] = '{default: 8'h00};

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_oe ? mem[ram_addr] : 8'h00;

  ram_arbiter #(.AW(4), .DW(8), .MAXBURST(4)) dut (
    .clk(clk), .clr(clr),
    .cpu_ramoa(cpu_ramoa), .cpu_ramwa(cpu_ramwa), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_boundary(cpu_boundary),
    .cpu_hold(cpu_hold), .host_req(host_req), .host_gnt(host_gnt),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_rdata(ram_rdata), .err(err),
    .dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b0; cpu_ramoa = 1'b0; cpu_ramwa = 1'b0; cpu_boundary = 1'b1;
    cpu_addr = 4'h0; cpu_wdata = 8'h00; host_req = 1'b0; host_valid = 1'b0;
    host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
    #1;
    chk1("rst_hold", cpu_hold, 1'b0);
    chk1("rst_gnt", host_gnt, 1'b0);
    chk1("rst_ready", host_ready, 1'b0);
    chk1("rst_rvalid", host_rvalid, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk8("rst_rdata", host_rdata, 8'h00);
    chk8("rst_state", 8'(dbg_state), 8'(ST_CPU));
    step(); step();
    clr = 1'b1;
    step();

    // Grant latency with boundary already high
    host_req = 1'b1;
    step();
    chk1("lat_hold_e1", cpu_hold, 1'b1);
    chk1("lat_gnt_e1", host_gnt, 1'b0);
    step();
    chk1("lat_gnt_e2", host_gnt, 1'b1);
    chk1("lat_ready_e2", host_ready, 1'b1);

    // Write 0x3C to 0xA, then read it back
    host_valid = 1'b1; host_we = 1'b1; host_addr = 4'hA; host_wdata = 8'h3C;
    step();
    chk8("wr_mem_a", mem[10], 8'h3C);
    chk1("wr_no_rvalid", host_rvalid, 1'b0);
    host_we = 1'b0;
    step();
    chk1("rd_rvalid", host_rvalid, 1'b1);
    chk8("rd_rdata", host_rdata, 8'h3C);
    host_valid = 1'b0;
    step();
    chk1("rd_rvalid_pulse", host_rvalid, 1'b0);

    // Final write coincides with release
    host_valid = 1'b1; host_we = 1'b1; host_addr = 4'h5; host_wdata = 8'h77; host_req = 1'b0;
    step();
    host_valid = 1'b0;
    chk8("rel_mem_5", mem[5], 8'h77);
    chk1("rel_gnt", host_gnt, 1'b0);
    chk1("rel_hold", cpu_hold, 1'b0);
    chk1("rel_ready", host_ready, 1'b0);

    // Delayed boundary: no grant until one edge after boundary rises
    host_req = 1'b1; cpu_boundary = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("dly_gnt_low", host_gnt, 1'b0);
    end
    chk1("dly_hold", cpu_hold, 1'b1);
    cpu_boundary = 1'b1;
    step();
    chk1("dly_gnt", host_gnt, 1'b1);

    // Six back-to-back writes with MAXBURST=4
    host_valid = 1'b1; host_we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      host_addr  = 4'(i);
      host_wdata = 8'h10 + 8'(i);
      chk1("burst_ready", host_ready, (i < 4) ? 1'b1 : 1'b0);
      step();
    end
    host_valid = 1'b0;
    chk8("burst_mem0", mem[0], 8'h10);
    chk8("burst_mem3", mem[3], 8'h13);
    chk8("burst_mem4", mem[4], 8'h00);
    chk8("burst_mem5", mem[5], 8'h77);
    chk1("cool_gnt", host_gnt, 1'b0);
    chk1("cool_hold", cpu_hold, 1'b0);
    chk8("cool_state", 8'(dbg_state), 8'(ST_COOL));
    step(); step();
    chk8("cool_waits", 8'(dbg_state), 8'(ST_COOL));
    cpu_boundary = 1'b0;
    step();
    chk8("cool_to_cpu", 8'(dbg_state), 8'(ST_CPU));
    chk1("cool_gnt2", host_gnt, 1'b0);
    step();
    chk1("regrant_hold", cpu_hold, 1'b1);
    cpu_boundary = 1'b1;
    step();
    chk1("regrant_gnt", host_gnt, 1'b1);

    // CPU strobe while host owns the RAM
    cpu_ramwa = 1'b1; cpu_addr = 4'h7; cpu_wdata = 8'hEE; cpu_ramoa = 1'b1;
    #1;
    chk8("host_cpu_rdata", cpu_rdata, 8'h00);
    cpu_ramoa = 1'b0;
    step();
    cpu_ramwa = 1'b0;
    chk8("err_mem7", mem[7], 8'h00);
    chk1("err_set", err, 1'b1);
    step();
    chk1("err_sticky", err, 1'b1);

    // Release, then CPU read through the mux
    host_req = 1'b0;
    step();
    cpu_ramoa = 1'b1; cpu_addr = 4'hA;
    #1;
    chk8("cpu_rd_a", cpu_rdata, 8'h3C);
    cpu_ramoa = 1'b0;
    step();
    chk1("err_sticky2", err, 1'b1);

    // Asynchronous reset during a host write
    host_req = 1'b1;
    step(); step();
    chk1("pre_rst_gnt", host_gnt, 1'b1);
    host_valid = 1'b1; host_we = 1'b1; host_addr = 4'hB; host_wdata = 8'h55;
    #1;
    chk1("pre_rst_we", ram_we, 1'b1);
    clr = 1'b0;
    #1;
    chk1("arst_we", ram_we, 1'b0);
    chk1("arst_gnt", host_gnt, 1'b0);
    chk1("arst_err", err, 1'b0);
    chk8("arst_state", 8'(dbg_state), 8'(ST_CPU));
    host_valid = 1'b0; host_req = 1'b0;
    step();
    clr = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
